reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   General-purpose register file for the 16-bit datapath: 16 registers r0..r15.
//   Write data comes from the ALU result bus; a per-register enable vector selects the destination(s).
//   All 16 register contents are exposed in parallel for the read muxes downstream.
//   Writes are synchronous to one clock; reset is asynchronous.
// PARAMETERS
//   DATA_WIDTH  16  width of each register, ALUBus and every rN output
// PORTS
//   clk        input   1           system clock; rising edge active
//   reset      input   1           asynchronous, active-low reset; clears all registers
//   ALUBus     input   DATA_WIDTH  write data (ALU result bus)
//   regEnable  input   16          write enable; bit i selects register ri
//   r0..r15    output  DATA_WIDTH  current contents of registers r0..r15 (16 separate ports)
// BEHAVIOUR
//   - Reset: reset==0 immediately and asynchronously forces r0..r15 = 16'h0000, independent of clk.
//     - Held reset: all writes are ignored.
//     - Reset deassertion (0->1): the first write takes effect at the next rising clk edge.
//     - Reset mid-operation: any pending write is discarded; contents become 0.
//   - Write: on each rising clk edge with reset==1, every register ri with regEnable[i]==1 loads ALUBus.
//     - Write latency is 1 clock: new value is visible on ri immediately after that edge.
//     - No same-cycle bypass: ri shows the old value until the edge.
//   - regEnable bits are independent; no one-hot check is performed.
//     - Multiple bits set: all selected registers load the same ALUBus value on the same edge.
//     - regEnable==0: no register changes; all contents are held indefinitely.
//   - Hold: registers with regEnable[i]==0 keep their value on every edge.
//   - r0 is an ordinary writable register, not hardwired to zero.
//   - Outputs come directly from flops: no combinational path from ALUBus/regEnable to rN.
//   - ALUBus is stored unmodified across the full 16 bits (0..65535); no sign handling.
//   - No read-side addressing inside this block; all 16 values are always driven.
// TESTING
//   1. Reset: hold reset=0 with random ALUBus and regEnable=16'hFFFF across edges
//      -> r0..r15 all 0, stay 0.
//   2. Sequential random write/readback: for i=0..15, set regEnable=1<<i and ALUBus=random
//      -> after next edge ri equals that value; all other registers unchanged.
//   3. Retention: write value i into ri for i=0..15, then regEnable=0 for many cycles
//      -> r0=0, r1=1, ... r15=15 still held.
//   4. Reverse order: write value i into r(15-i) for i=0..15
//      -> r0=15, r1=14, ... r15=0; each earlier write is overwritten only in its own register.
//   5. Multi-enable: regEnable=16'h8001, ALUBus=16'hA5A5 -> r0=r15=16'hA5A5, others untouched;
//      boundary values 16'hFFFF and 16'h0000 round-trip exactly.
//   6. Async reset mid-run: load nonzero values, pull reset=0 between clk edges
//      -> all rN=0 before the next edge; release and write r3=16'h1234 -> only r3 nonzero.

Source files
------------

// File: rtl/reg_file.sv
// General-purpose register file: sixteen DATA_WIDTH registers.
// Each register is loaded from ALUBus under its own enable bit, and all registers are driven out in parallel.
module reg_file #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALUBus,
    input  logic [15:0]           regEnable,
    output logic [DATA_WIDTH-1:0] r0,
    output logic [DATA_WIDTH-1:0] r1,
    output logic [DATA_WIDTH-1:0] r2,
    output logic [DATA_WIDTH-1:0] r3,
    output logic [DATA_WIDTH-1:0] r4,
    output logic [DATA_WIDTH-1:0] r5,
    output logic [DATA_WIDTH-1:0] r6,
    output logic [DATA_WIDTH-1:0] r7,
    output logic [DATA_WIDTH-1:0] r8,
    output logic [DATA_WIDTH-1:0] r9,
    output logic [DATA_WIDTH-1:0] r10,
    output logic [DATA_WIDTH-1:0] r11,
    output logic [DATA_WIDTH-1:0] r12,
    output logic [DATA_WIDTH-1:0] r13,
    output logic [DATA_WIDTH-1:0] r14,
    output logic [DATA_WIDTH-1:0] r15
);

    logic [DATA_WIDTH-1:0] regs [16];

    // One flop bank per register; enables are independent, so several banks may load at once.
    for (genvar g = 0; g < 16; g++) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs[g] <= '0;
            end else if (regEnable[g]) begin
                regs[g] <= ALUBus;
            end
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file.
// Applies a vector table and random writes, and checks all sixteen registers against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
    logic [15:0] rv [16];
    logic [15:0] model [16];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] en;
        logic [15:0] bus;
        int          ia;
        logic [15:0] va;
        int          ib;
        logic [15:0] vb;
    } vec_t;

    vec_t vecs [6];

    reg_file #(.DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .ALUBus(ALUBus), .regEnable(regEnable),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13),
        .r14(r14), .r15(r15)
    );

    always #5 clk = ~clk;

    assign rv[0]  = r0;
    assign rv[1]  = r1;
    assign rv[2]  = r2;
    assign rv[3]  = r3;
    assign rv[4]  = r4;
    assign rv[5]  = r5;
    assign rv[6]  = r6;
    assign rv[7]  = r7;
    assign rv[8]  = r8;
    assign rv[9]  = r9;
    assign rv[10] = r10;
    assign rv[11] = r11;
    assign rv[12] = r12;
    assign rv[13] = r13;
    assign rv[14] = r14;
    assign rv[15] = r15;

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s r%0d got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 16; i++) chk(name, i, rv[i], model[i]);
    endtask

    // Model update happens before the edge; the DUT is sampled 1 time unit after it.
    task automatic step();
        if (!reset) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (regEnable[i]) model[i] = ALUBus;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] en, input logic [15:0] bus);
        regEnable = en;
        ALUBus    = bus;
        step();
    endtask

    initial begin
        vecs[0] = '{16'h8001, 16'hA5A5, 0, 16'hA5A5, 15, 16'hA5A5};
        vecs[1] = '{16'h0002, 16'hFFFF, 1, 16'hFFFF, 0, 16'hA5A5};
        vecs[2] = '{16'h0002, 16'h0000, 1, 16'h0000, 15, 16'hA5A5};
        vecs[3] = '{16'h0000, 16'h1111, 1, 16'h0000, 2, 16'h000D};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 7, 16'hFFFF, 15, 16'hFFFF};
        vecs[5] = '{16'h0000, 16'h0000, 3, 16'hFFFF, 0, 16'hFFFF};

        for (int i = 0; i < 16; i++) model[i] = '0;
        reset     = 1'b0;
        regEnable = 16'hFFFF;
        ALUBus    = 16'($urandom);
        #1;
        check_all("reset_async");

        for (int c = 0; c < 3; c++) begin
            ALUBus = 16'($urandom);
            step();
            check_all("reset_held");
        end

        @(negedge clk);
        reset     = 1'b1;
        regEnable = 16'h0000;
        #1;
        check_all("reset_release");

        for (int i = 0; i < 16; i++) begin
            wr(16'(1 << i), 16'($urandom));
            check_all("seq_write");
        end

        for (int i = 0; i < 16; i++) wr(16'(1 << i), 16'(i));
        for (int c = 0; c < 20; c++) wr(16'h0000, 16'($urandom));
        for (int i = 0; i < 16; i++) chk("retention", i, rv[i], 16'(i));

        for (int i = 0; i < 16; i++) wr(16'(1 << (15 - i)), 16'(i));
        for (int i = 0; i < 16; i++) chk("reverse", i, rv[i], 16'(15 - i));

        foreach (vecs[k]) begin
            wr(vecs[k].en, vecs[k].bus);
            chk("vec_a", vecs[k].ia, rv[vecs[k].ia], vecs[k].va);
            chk("vec_b", vecs[k].ib, rv[vecs[k].ib], vecs[k].vb);
            check_all("vec_model");
        end

        // Random traffic; new inputs must not show up until the following edge.
        for (int c = 0; c < 200; c++) begin
            regEnable = 16'($urandom);
            ALUBus    = 16'($urandom);
            if (c % 10 == 0) begin
                #2;
                check_all("no_bypass");
            end
            step();
            check_all("random");
        end

        wr(16'hFFFF, 16'hBEEF);
        chk("preload", 9, rv[9], 16'hBEEF);
        regEnable = 16'hFFFF;
        ALUBus    = 16'h5555;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        check_all("reset_midrun");
        step();
        check_all("reset_midrun_held");

        @(negedge clk);
        reset = 1'b1;
        wr(16'h0008, 16'h1234);
        chk("post_reset_r3", 3, rv[3], 16'h1234);
        check_all("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
